// File: rtl/fifo_sram_pkg.sv
// fifo_sram_pkg: shared status type and default sizing for the SRAM-backed FIFO
package fifo_sram_pkg;
  localparam int DEFAULT_DEPTH      = 512;
  localparam int DEFAULT_DATA_WIDTH = 36;
  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_status_t;
endpackage

// File: rtl/fifo_sram_mem.sv
// fifo_sram_mem: 1R1W RAM with registered read and no reset, inferable as block RAM
module fifo_sram_mem #(
  parameter int DATA_WIDTH = 36,
  parameter int DEPTH      = 512,
  localparam int AW        = $clog2(DEPTH)
)(
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  // write port and registered read port; rdata holds when no read is issued
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/fifo_sram_v4.sv
// fifo_sram_v4: first-word-fall-through FIFO over a registered-read RAM; FIFO_SRAM_ERR_EN enables sticky overflow/underflow flags
module fifo_sram_v4
  import fifo_sram_pkg::*;
#(
  parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
  parameter int DEPTH           = DEFAULT_DEPTH,
  parameter int ALMOST_FULL_TH  = DEPTH - 8,
  parameter int ALMOST_EMPTY_TH = 8,
  localparam int CNT_W          = $clog2(DEPTH) + 1
)(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic [CNT_W-1:0]      usage_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0]         wptr, rptr;
  logic [CNT_W-1:0]      usage, ram_cnt;
  logic                  head_v, push_acc, pop_acc, rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  fifo_status_t          st;
  // the RAM read register doubles as the head register; head_v marks it valid
  assign ram_cnt  = usage - CNT_W'(head_v);
  assign push_acc = push_i & ~st.full & ~flush_i;
  assign pop_acc  = pop_i & head_v & ~flush_i;
  assign rd_en    = (ram_cnt != '0) & (~head_v | pop_acc) & ~flush_i;
  assign st.full         = usage == CNT_W'(DEPTH);
  assign st.empty        = ~head_v;
  assign st.almost_full  = usage >= CNT_W'(ALMOST_FULL_TH);
  assign st.almost_empty = usage <= CNT_W'(ALMOST_EMPTY_TH);
  fifo_sram_mem #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk   (clk_i),
    .we    (push_acc),
    .waddr (wptr),
    .wdata (data_i),
    .re    (rd_en),
    .raddr (rptr),
    .rdata (rd_data)
  );
  // pointers, occupancy and head-valid; flush drops everything including an in-flight read
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      wptr   <= '0;
      rptr   <= '0;
      usage  <= '0;
      head_v <= 1'b0;
    end else if (flush_i) begin
      wptr   <= '0;
      rptr   <= '0;
      usage  <= '0;
      head_v <= 1'b0;
    end else begin
      if (push_acc) wptr <= wptr + AW'(1);
      if (rd_en) rptr <= rptr + AW'(1);
      usage  <= usage + CNT_W'(push_acc) - CNT_W'(pop_acc);
      head_v <= rd_en | (head_v & ~pop_acc);
    end
`ifdef FIFO_SRAM_ERR_EN
  logic ovf, unf;
  // sticky error flags, cleared only by flush or reset
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else if (flush_i) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (push_i & st.full) ovf <= 1'b1;
      if (pop_i & ~head_v) unf <= 1'b1;
    end
  assign overflow_o  = ovf;
  assign underflow_o = unf;
`else
  assign overflow_o  = 1'b0;
  assign underflow_o = 1'b0;
`endif
  // the unreset RAM output is masked to zero until a valid head is loaded
  assign data_o         = head_v ? rd_data : '0;
  assign usage_o        = usage;
  assign full_o         = st.full;
  assign empty_o        = st.empty;
  assign almost_full_o  = st.almost_full;
  assign almost_empty_o = st.almost_empty;
endmodule

// File: tb/tb_fifo_sram_v4.sv
// tb_fifo_sram_v4: directed self-checking bench for fifo_sram_v4 at DEPTH=8
module tb_fifo_sram_v4;
  localparam int DW = 36;
  localparam int CW = 4;
`ifdef FIFO_SRAM_ERR_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, push = 1'b0, pop = 1'b0;
  logic [DW-1:0] din = '0, dout;
  logic full, empty, afull, aempty, ovf, unf;
  logic [CW-1:0] usage;
  int tests = 0, fails = 0;
  fifo_sram_v4 #(.DATA_WIDTH(DW), .DEPTH(8), .ALMOST_FULL_TH(6), .ALMOST_EMPTY_TH(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .push_i(push), .data_i(din), .pop_i(pop),
    .data_o(dout), .full_o(full), .empty_o(empty), .almost_full_o(afull), .almost_empty_o(aempty),
    .usage_o(usage), .overflow_o(ovf), .underflow_o(unf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input logic p, input logic [DW-1:0] d, input logic q);
    push = p;
    din = d;
    pop = q;
    @(posedge clk);
    #1;
    push = 1'b0;
    pop = 1'b0;
  endtask
  task automatic chk_lvl(input string tag, input int u);
    chk({tag, "_usage"}, 64'(usage), 64'(u));
    chk({tag, "_aempty"}, 64'(aempty), 64'(u <= 2));
    chk({tag, "_afull"}, 64'(afull), 64'(u >= 6));
    chk({tag, "_full"}, 64'(full), 64'(u == 8));
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_usage"}, 64'(usage), 64'd0);
    chk({tag, "_empty"}, 64'(empty), 64'd1);
    chk({tag, "_full"}, 64'(full), 64'd0);
    chk({tag, "_aempty"}, 64'(aempty), 64'd1);
    chk({tag, "_afull"}, 64'(afull), 64'd0);
    chk({tag, "_ovf"}, 64'(ovf), 64'd0);
    chk({tag, "_unf"}, 64'(unf), 64'd0);
    chk({tag, "_data"}, 64'(dout), 64'd0);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_reset("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc(1'b1, 36'h123456789, 1'b0);
    chk("lat_usage1", 64'(usage), 64'd1);
    chk("lat_empty1", 64'(empty), 64'd1);
    cyc(1'b0, '0, 1'b0);
    chk("lat_empty2", 64'(empty), 64'd0);
    chk("lat_data2", 64'(dout), 64'h123456789);
    cyc(1'b0, '0, 1'b1);
    chk("lat_drain_usage", 64'(usage), 64'd0);
    chk("lat_drain_empty", 64'(empty), 64'd1);
    chk_lvl("sweep0", 0);
    for (int k = 0; k < 8; k++) begin
      cyc(1'b1, DW'(k), 1'b0);
      chk_lvl($sformatf("fill%0d", k + 1), k + 1);
    end
    cyc(1'b1, 36'hBAD, 1'b0);
    chk_lvl("drop", 8);
    chk("drop_ovf", 64'(ovf), 64'(ERR));
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("drain%0d_empty", k), 64'(empty), 64'd0);
      chk($sformatf("drain%0d_data", k), 64'(dout), 64'(k));
      chk_lvl($sformatf("drain%0d", k), 8 - k);
      cyc(1'b0, '0, 1'b1);
    end
    chk_lvl("drained", 0);
    chk("drained_empty", 64'(empty), 64'd1);
    flush = 1'b1;
    cyc(1'b0, '0, 1'b0);
    flush = 1'b0;
    chk("flush1_ovf", 64'(ovf), 64'd0);
    for (int i = 0; i < 4; i++) cyc(1'b1, DW'(100 + i), 1'b0);
    cyc(1'b0, '0, 1'b0);
    chk("st_usage", 64'(usage), 64'd4);
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("st%0d_empty", i), 64'(empty), 64'd0);
      chk($sformatf("st%0d_data", i), 64'(dout), 64'(100 + i));
      chk($sformatf("st%0d_usage", i), 64'(usage), 64'd4);
      cyc(1'b1, DW'(104 + i), 1'b1);
    end
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("st_tail%0d", i), 64'(dout), 64'(120 + i));
      cyc(1'b0, '0, 1'b1);
    end
    chk("st_end_empty", 64'(empty), 64'd1);
    cyc(1'b0, '0, 1'b1);
    chk("under_unf", 64'(unf), 64'(ERR));
    chk("under_usage", 64'(usage), 64'd0);
    for (int i = 0; i < 5; i++) cyc(1'b1, DW'(200 + i), 1'b0);
    cyc(1'b0, '0, 1'b0);
    chk("fl_pre_usage", 64'(usage), 64'd5);
    chk("fl_pre_unf", 64'(unf), 64'(ERR));
    flush = 1'b1;
    cyc(1'b1, 36'hEE, 1'b0);
    flush = 1'b0;
    chk_reset("flush");
    repeat (2) cyc(1'b0, '0, 1'b0);
    chk("fl_post_usage", 64'(usage), 64'd0);
    chk("fl_post_empty", 64'(empty), 64'd1);
    for (int i = 0; i < 3; i++) cyc(1'b1, DW'(300 + i), 1'b0);
    cyc(1'b0, '0, 1'b0);
    chk("ar_pre_usage", 64'(usage), 64'd3);
    chk("ar_pre_data", 64'(dout), 64'd300);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset("async");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc(1'b0, '0, 1'b1);
    chk("ar_unf", 64'(unf), 64'(ERR));
    chk("ar_usage", 64'(usage), 64'd0);
    chk("ar_empty", 64'(empty), 64'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
